// File: rtl/zx_video_gen.sv
// zx_video_gen -- ZX Spectrum display generator with VGA-style timing.
//
// Produces sync/enable timing from free-running pixel/line counters, fetches
// bitmap and attribute bytes for each 8-pixel cell from a screen RAM with a
// one-cycle registered read port, and renders ink/paper/bright/flash colour
// inside a SCALE-replicated 256x192 paper area surrounded by a border.
//
// Ports:
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   border_color[2:0]     border colour {G,R,B}, sampled every clock
//   vid_addr[12:0]        screen RAM byte address (0 = 0x4000)
//   vid_rd                read strobe; vid_data valid the following cycle
//   vid_data[7:0]         screen RAM read data
//   vga_r/g/b             colour outputs, COLOR_BITS each
//   vga_hs, vga_vs        active-low syncs
//   vga_de                display enable
//   frame_irq             one-clock pulse per frame (also advances flash)
//
// Build option: define SCANLINES_EN to halve the colour level on odd lines.
//
// Constraints: HB=(H_ACTIVE-256*SCALE)/2 must be >= 4 (the first cell fetch
// begins 4 clocks before the paper area) and VB=(V_ACTIVE-192*SCALE)/2 >= 0.

module zx_video_gen #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 11,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 31,
   parameter int SCALE        = 2,
   parameter int FLASH_FRAMES = 16,
   parameter int COLOR_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            border_color,
   output logic [12:0]           vid_addr,
   output logic                  vid_rd,
   input  logic [7:0]            vid_data,
   output logic [COLOR_BITS-1:0] vga_r,
   output logic [COLOR_BITS-1:0] vga_g,
   output logic [COLOR_BITS-1:0] vga_b,
   output logic                  vga_hs,
   output logic                  vga_vs,
   output logic                  vga_de,
   output logic                  frame_irq
);

   localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HB  = (H_ACTIVE - 256 * SCALE) / 2;
   localparam int VB  = (V_ACTIVE - 192 * SCALE) / 2;
   localparam int HCW = $clog2(HT);
   localparam int VCW = $clog2(VT);
   localparam int CPW = $clog2(8 * SCALE);
   localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   localparam logic [HCW-1:0] H_LAST   = HCW'(HT - 1);
   localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
   localparam logic [HCW-1:0] HS_BEG   = HCW'(H_ACTIVE + H_FP);
   localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HCW-1:0] PX_BEG   = HCW'(HB);
   localparam logic [HCW-1:0] PX_END   = HCW'(HB + 256 * SCALE);
   localparam logic [HCW-1:0] FETCH0   = HCW'(HB - 4);
   localparam logic [VCW-1:0] V_LAST   = VCW'(VT - 1);
   localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
   localparam logic [VCW-1:0] VS_BEG   = VCW'(V_ACTIVE + V_FP);
   localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VCW-1:0] PY_BEG   = VCW'(VB);
   localparam logic [VCW-1:0] PY_END   = VCW'(VB + 192 * SCALE);
   localparam logic [CPW-1:0] CP_LAST  = CPW'(8 * SCALE - 1);
   localparam logic [1:0]     SUB_LAST = 2'(SCALE - 1);
   localparam logic [FCW-1:0] FF_LAST  = FCW'(FLASH_FRAMES - 1);

   // Counter state and its next value. Fetch strobes and frame_irq are
   // registered from the next-state values so they line up with the counter
   // state itself; video outputs are registered from the current state and so
   // lag it by one clock.
   logic [HCW-1:0] hc, hc_n;
   logic [VCW-1:0] vc, vc_n;
   logic           hwrap;
   logic [7:0]     y, y_n;          // paper row, valid on paper lines
   logic [1:0]     ysub, ysub_n;    // line replication phase
   logic           fa, fa_n;        // inside the per-line fetch window
   logic [CPW-1:0] cp, cp_n;        // clock within cell, 0 = cell start - 4
   logic [4:0]     n, n_n;          // cell index
   logic           pl, pl_n;        // paper line

   logic [7:0]     bm_hold, at_hold;
   logic [7:0]     sh, at;
   logic [1:0]     ps;              // pixel replication phase
   logic [FCW-1:0] fc;
   logic           phase;

   assign hwrap = (hc == H_LAST);
   assign pl    = (vc >= PY_BEG) && (vc < PY_END);
   assign pl_n  = (vc_n >= PY_BEG) && (vc_n < PY_END);

   always_comb begin
      hc_n   = hwrap ? '0 : hc + 1'b1;
      vc_n   = vc;
      y_n    = y;
      ysub_n = ysub;
      if (hwrap) begin
         vc_n = (vc == V_LAST) ? '0 : vc + 1'b1;
         if (vc_n == PY_BEG) begin
            y_n    = '0;
            ysub_n = '0;
         end else if (ysub == SUB_LAST) begin
            ysub_n = '0;
            y_n    = y + 1'b1;
         end else begin
            ysub_n = ysub + 1'b1;
         end
      end
   end

   // Fetch window: 32 cells of 8*SCALE clocks starting 4 clocks ahead of
   // the paper area.
   always_comb begin
      fa_n = fa;
      cp_n = cp;
      n_n  = n;
      if (hc_n == FETCH0) begin
         fa_n = 1'b1;
         cp_n = '0;
         n_n  = '0;
      end else if (fa) begin
         if (cp == CP_LAST) begin
            cp_n = '0;
            n_n  = n + 1'b1;
            if (n == 5'd31) fa_n = 1'b0;
         end else begin
            cp_n = cp + 1'b1;
         end
      end
   end

   logic        rd_n;
   logic [12:0] addr_n;
   logic        irq_n;

   always_comb begin
      rd_n   = fa_n && pl_n && (cp_n == CPW'(0) || cp_n == CPW'(1));
      addr_n = (cp_n == CPW'(0)) ? {y_n[7:6], y_n[2:0], y_n[5:3], n_n}
                                 : {3'b110, y_n[7:3], n_n};
      irq_n  = (vc_n == VS_BEG) && (hc_n == '0);
   end

   // Colour decode from current state.
   function automatic logic [COLOR_BITS-1:0] lvl(input logic on, input logic bright);
      logic [COLOR_BITS-1:0] full;
      full = '1;
      if (!on) return '0;
      return bright ? full : ~(full >> 2);
   endfunction

   logic       de_c, paper_c, hs_c, vs_c;
   logic [2:0] cidx;
   logic [COLOR_BITS-1:0] r_c, g_c, b_c;

   always_comb begin
      de_c    = (hc < H_ACT) && (vc < V_ACT);
      paper_c = (hc >= PX_BEG) && (hc < PX_END) && pl;
      hs_c    = !((hc >= HS_BEG) && (hc < HS_END));
      vs_c    = !((vc >= VS_BEG) && (vc < VS_END));
      // Pixel XOR flash-swap picks ink (1) or paper (0).
      cidx    = (sh[7] ^ (at[7] & phase)) ? at[2:0] : at[5:3];
      r_c = '0;
      g_c = '0;
      b_c = '0;
      if (de_c) begin
         if (paper_c) begin
            g_c = lvl(cidx[2], at[6]);
            r_c = lvl(cidx[1], at[6]);
            b_c = lvl(cidx[0], at[6]);
         end else begin
            g_c = lvl(border_color[2], 1'b0);
            r_c = lvl(border_color[1], 1'b0);
            b_c = lvl(border_color[0], 1'b0);
         end
      end
`ifdef SCANLINES_EN
      if (vc[0]) begin
         r_c = r_c >> 1;
         g_c = g_c >> 1;
         b_c = b_c >> 1;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hc        <= '0;
         vc        <= '0;
         y         <= '0;
         ysub      <= '0;
         fa        <= 1'b0;
         cp        <= '0;
         n         <= '0;
         bm_hold   <= '0;
         at_hold   <= '0;
         sh        <= '0;
         at        <= '0;
         ps        <= '0;
         fc        <= '0;
         phase     <= 1'b0;
         vid_rd    <= 1'b0;
         vid_addr  <= '0;
         frame_irq <= 1'b0;
         vga_r     <= '0;
         vga_g     <= '0;
         vga_b     <= '0;
         vga_hs    <= 1'b1;
         vga_vs    <= 1'b1;
         vga_de    <= 1'b0;
      end else begin
         hc   <= hc_n;
         vc   <= vc_n;
         y    <= y_n;
         ysub <= ysub_n;
         fa   <= fa_n;
         cp   <= cp_n;
         n    <= n_n;

         vid_rd <= rd_n;
         if (rd_n) vid_addr <= addr_n;

         // Read data arrives one clock after each strobe.
         if (fa && pl && cp == CPW'(1)) bm_hold <= vid_data;
         if (fa && pl && cp == CPW'(2)) at_hold <= vid_data;

         // Load on the clock before cell start so pixel 0 is ready at cs.
         if (fa && pl && cp == CPW'(3)) begin
            sh <= bm_hold;
            at <= at_hold;
            ps <= '0;
         end else if (ps == SUB_LAST) begin
            ps <= '0;
            sh <= {sh[6:0], 1'b0};
         end else begin
            ps <= ps + 1'b1;
         end

         frame_irq <= irq_n;
         if (irq_n) begin
            if (fc == FF_LAST) begin
               fc    <= '0;
               phase <= ~phase;
            end else begin
               fc <= fc + 1'b1;
            end
         end

         vga_r  <= r_c;
         vga_g  <= g_c;
         vga_b  <= b_c;
         vga_hs <= hs_c;
         vga_vs <= vs_c;
         vga_de <= de_c;
      end
   end

endmodule
